mat_stream_reader: RTL and testbench

Sequencer that dumps N consecutive rows or columns of a matrix register as a stream of WIDTH-element vectors with a valid/ready handshake. It drives the matrix register's read port (read op plus index) and accepts its combinational read data. Its output stream feeds the vector store / unload path, so a whole matrix can leave the register at one vector per cycle without a controller stepping each index.

---
 rtl/mat_stream_reader_if.sv | 30 +++
 rtl/mat_stream_reader.sv | 128 ++++++++++++
 tb/tb_mat_stream_reader.sv | 381 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mat_stream_reader_if.sv
// Output stream of the matrix reader: one WIDTH-element vector per
// handshake. Each element is a 32-bit shortreal bit pattern that the
// reader passes through untouched.
interface mat_stream_reader_if #(
    parameter int WIDTH = 128
) ();
    localparam int WIDTH_ADDR_SIZE = $clog2(WIDTH);

    logic                       out_valid;
    logic                       out_ready;
    logic [WIDTH-1:0][31:0]     out_data;
    logic [WIDTH_ADDR_SIZE-1:0] out_index;
    logic                       out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mat_stream_reader.sv
// Streams N consecutive rows or columns of the matrix register out as
// vectors, one per cycle when the consumer keeps up.
//
// state  | meaning
// IDLE   | waiting for start; read port disabled
// STREAM | presenting the next index to the register, loading on free slot
// DRAIN  | final vector held until the consumer takes it
module mat_stream_reader #(
    parameter int WIDTH           = 128,
    parameter int WIDTH_ADDR_SIZE = $clog2(WIDTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         start_col,
    input  logic [WIDTH_ADDR_SIZE:0]     start_count,
    input  logic [WIDTH_ADDR_SIZE-1:0]   start_base,
    output logic [1:0]                   read_op,
    output logic [WIDTH_ADDR_SIZE-1:0]   read_param1,
    output logic [WIDTH_ADDR_SIZE-1:0]   read_param2,
    input  logic [WIDTH-1:0][31:0]       rd_data,
    mat_stream_reader_if.master          out,
    output logic                         busy,
    output logic                         done
);
    typedef enum logic [1:0] {
        MAT_READ_DISABLE = 2'd0,
        MAT_READ_ROW     = 2'd1,
        MAT_READ_COL     = 2'd2
    } MatDataReadOp_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    localparam logic [WIDTH_ADDR_SIZE:0]   COUNT_MAX = (WIDTH_ADDR_SIZE+1)'(WIDTH);
    localparam logic [WIDTH_ADDR_SIZE:0]   CNT_ONE   = (WIDTH_ADDR_SIZE+1)'(1);
    localparam logic [WIDTH_ADDR_SIZE-1:0] IDX_MAX   = WIDTH_ADDR_SIZE'(WIDTH - 1);
    localparam logic [WIDTH_ADDR_SIZE-1:0] IDX_ONE   = WIDTH_ADDR_SIZE'(1);

    state_t                     state;
    logic                       col_mode;
    logic [WIDTH_ADDR_SIZE-1:0] idx;
    logic [WIDTH_ADDR_SIZE:0]   remaining;

    logic [WIDTH_ADDR_SIZE:0]   count_eff;
    logic [WIDTH_ADDR_SIZE-1:0] idx_next;
    logic                       load;

    // Count normalisation, index wrap and output-slot availability
    always_comb begin
        count_eff = start_count;
        if (start_count == '0 || start_count > COUNT_MAX) begin
            count_eff = COUNT_MAX;
        end
        idx_next = (idx == IDX_MAX) ? '0 : idx + IDX_ONE;
        load     = !out.out_valid || out.out_ready;
    end

    // Read port decodes from registered state only, so the register's
    // combinational read data never loops back through an input
    always_comb begin
        read_op     = MAT_READ_DISABLE;
        read_param1 = '0;
        if (state == ST_STREAM) begin
            read_op     = col_mode ? MAT_READ_COL : MAT_READ_ROW;
            read_param1 = idx;
        end
    end

    assign read_param2 = '0;
    assign busy        = (state != ST_IDLE);

    // Sequencer: latch the request, load vectors into the output slot, drain
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_IDLE;
            col_mode      <= 1'b0;
            idx           <= '0;
            remaining     <= '0;
            out.out_valid <= 1'b0;
            out.out_data  <= '0;
            out.out_index <= '0;
            out.out_last  <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        col_mode  <= start_col;
                        idx       <= start_base;
                        remaining <= count_eff;
                        state     <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // A load frees the slot and refills it at the same edge,
                    // which is what gives one vector per cycle
                    if (load) begin
                        out.out_data  <= rd_data;
                        out.out_index <= idx;
                        out.out_valid <= 1'b1;
                        out.out_last  <= (remaining == CNT_ONE);
                        idx           <= idx_next;
                        remaining     <= remaining - CNT_ONE;
                        if (remaining == CNT_ONE) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out.out_ready) begin
                        out.out_valid <= 1'b0;
                        out.out_last  <= 1'b0;
                        done          <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mat_stream_reader.sv
// Bench for mat_stream_reader at WIDTH=8 against a tagged matrix model.
module tb_mat_stream_reader;
    localparam int W  = 8;
    localparam int AW = 3;

    localparam logic [1:0] OP_DIS = 2'd0;
    localparam logic [1:0] OP_ROW = 2'd1;
    localparam logic [1:0] OP_COL = 2'd2;

    typedef logic [W-1:0][31:0] vec_t;
    typedef struct packed {
        logic [AW-1:0] idx;
        logic          last;
        vec_t          data;
    } exp_t;

    logic          clock;
    logic          reset;
    logic          start;
    logic          start_col;
    logic [AW:0]   start_count;
    logic [AW-1:0] start_base;
    logic [1:0]    read_op;
    logic [AW-1:0] read_param1;
    logic [AW-1:0] read_param2;
    vec_t          rd_data;
    logic          busy;
    logic          done;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    mat_stream_reader_if #(.WIDTH(W)) sif ();

    mat_stream_reader #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .start_col   (start_col),
        .start_count (start_count),
        .start_base  (start_base),
        .read_op     (read_op),
        .read_param1 (read_param1),
        .read_param2 (read_param2),
        .rd_data     (rd_data),
        .out         (sif),
        .busy        (busy),
        .done        (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // mem[r][c] = 10r+c, tagged in the top byte so no element is ever zero
    function automatic logic [31:0] mem_val(int r, int c);
        return 32'hA500_0000 | 32'(10 * r + c);
    endfunction

    function automatic vec_t row_vec(int r);
        vec_t v;
        for (int c = 0; c < W; c++) v[c] = mem_val(r, c);
        return v;
    endfunction

    function automatic vec_t col_vec(int col);
        vec_t v;
        for (int i = 0; i < W; i++) v[i] = mem_val(i, col);
        return v;
    endfunction

    // Combinational matrix register read port
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < W; i++) begin
            if (read_op == OP_ROW)      rd_data[i] = mem_val(int'(read_param1), i);
            else if (read_op == OP_COL) rd_data[i] = mem_val(i, int'(read_param1));
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({sif.out_valid, sif.out_last, sif.out_index, busy, done, read_op, read_param1, read_param2} !== '0)
            $display("FAIL reset_ctrl got valid=%0b last=%0b index=%0d busy=%0b done=%0b op=%0d p1=%0d p2=%0d, want all 0",
                     sif.out_valid, sif.out_last, sif.out_index, busy, done, read_op, read_param1, read_param2);
        else n_pass++;
        n_checks++;
        if (sif.out_data !== '0) $display("FAIL reset_data got %h want 0", sif.out_data);
        else n_pass++;
        reset = 1'b0;
    endtask

    task automatic test_rows();
        exp_t e, obs;
        int k = 0;
        bit seen = 0;
        for (int r = 0; r < 4; r++) exp_q.push_back(exp_t'{idx: AW'(r), last: 1'(r == 3), data: row_vec(r)});
        @(negedge clock);
        start = 1; start_col = 0; start_count = 4; start_base = 0; sif.out_ready = 1;
        @(negedge clock);
        start = 0;
        n_checks++;
        if (busy !== 1'b1 || read_op !== OP_ROW || read_param1 !== 3'd0)
            $display("FAIL rows_first_read got busy=%0b op=%0d p1=%0d, want 1 %0d 0", busy, read_op, read_param1, OP_ROW);
        else n_pass++;
        for (int c = 2; c <= 20 && !seen; c++) begin
            @(negedge clock);
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_index, sif.out_last, sif.out_data};
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                n_checks++;
                if (obs !== e || c !== 2 + k)
                    $display("FAIL rows_vec k=%0d got idx=%0d last=%0b cyc=%0d data=%h, want idx=%0d last=%0b cyc=%0d data=%h",
                             k, obs.idx, obs.last, c, obs.data, e.idx, e.last, 2 + k, e.data);
                else n_pass++;
                k++;
            end
            if (done) begin
                seen = 1;
                n_checks++;
                if (c !== 6 || busy !== 1'b0 || exp_q.size() != 0)
                    $display("FAIL rows_done got cyc=%0d busy=%0b left=%0d, want cyc=6 busy=0 left=0", c, busy, exp_q.size());
                else n_pass++;
            end
        end
        if (!seen) begin n_checks++; $display("FAIL rows_timeout got no done, want done at cyc 6"); end
        exp_q.delete();
    endtask

    task automatic test_cols();
        exp_t e, obs;
        bit seen = 0;
        for (int k = 0; k < 4; k++)
            exp_q.push_back(exp_t'{idx: AW'((6 + k) % W), last: 1'(k == 3), data: col_vec((6 + k) % W)});
        @(negedge clock);
        start = 1; start_col = 1; start_count = 4; start_base = 6; sif.out_ready = 1;
        @(negedge clock);
        start = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            if (c > 1) @(negedge clock);
            if (c <= 4) begin
                n_checks++;
                if (read_op !== OP_COL || read_param1 !== AW'((5 + c) % W))
                    $display("FAIL cols_read cyc=%0d got op=%0d p1=%0d, want op=%0d p1=%0d", c, read_op, read_param1, OP_COL, (5 + c) % W);
                else n_pass++;
            end
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_index, sif.out_last, sif.out_data};
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                n_checks++;
                if (obs !== e)
                    $display("FAIL cols_vec cyc=%0d got idx=%0d last=%0b data=%h, want idx=%0d last=%0b data=%h",
                             c, obs.idx, obs.last, obs.data, e.idx, e.last, e.data);
                else n_pass++;
            end
            if (done) begin
                seen = 1;
                n_checks++;
                if (c !== 6 || exp_q.size() != 0)
                    $display("FAIL cols_done got cyc=%0d left=%0d, want cyc=6 left=0", c, exp_q.size());
                else n_pass++;
            end
        end
        if (!seen) begin n_checks++; $display("FAIL cols_timeout got no done, want done at cyc 6"); end
        exp_q.delete();
    endtask

    task automatic test_backpressure();
        logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        exp_t e, obs;
        logic [AW+2+$bits(exp_t)-1:0] snap, prev;
        bit stalled = 0, seen = 0;
        int last_hs = -10;
        for (int k = 0; k < 5; k++) exp_q.push_back(exp_t'{idx: AW'(2 + k), last: 1'(k == 4), data: row_vec(2 + k)});
        @(negedge clock);
        start = 1; start_col = 0; start_count = 5; start_base = 2; sif.out_ready = pat[0];
        prev = '0;
        for (int c = 1; c <= 30 && !seen; c++) begin
            @(negedge clock);
            start = 0;
            sif.out_ready = (c <= 6) ? pat[c-1] : 1'b1;
            obs  = {sif.out_index, sif.out_last, sif.out_data};
            snap = {obs, read_op, read_param1};
            if (stalled) begin
                n_checks++;
                if (snap !== prev)
                    $display("FAIL bp_stable cyc=%0d got idx=%0d op=%0d p1=%0d data=%h, want unchanged idx=%0d",
                             c, obs.idx, read_op, read_param1, obs.data, prev[AW+2+$bits(exp_t)-1 -: AW]);
                else n_pass++;
            end
            stalled = sif.out_valid && !sif.out_ready;
            prev = snap;
            if (sif.out_valid && sif.out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                n_checks++;
                if (obs !== e)
                    $display("FAIL bp_vec cyc=%0d got idx=%0d last=%0b data=%h, want idx=%0d last=%0b data=%h",
                             c, obs.idx, obs.last, obs.data, e.idx, e.last, e.data);
                else n_pass++;
                if (obs.last) last_hs = c;
            end
            if (done) begin
                seen = 1;
                n_checks++;
                if (c !== last_hs + 1 || c !== 10 || exp_q.size() != 0)
                    $display("FAIL bp_done got cyc=%0d last_hs=%0d left=%0d, want cyc=10 after last_hs=9 left=0", c, last_hs, exp_q.size());
                else n_pass++;
            end
        end
        if (!seen) begin n_checks++; $display("FAIL bp_timeout got no done, want done at cyc 10"); end
        exp_q.delete();
    endtask

    // count 0 then count 9, the second started in the done cycle of the first
    task automatic test_back_to_back();
        exp_t e, obs;
        int base;
        bit seen;
        @(negedge clock);
        start = 1; start_col = 0; start_count = 0; start_base = 3; sif.out_ready = 1;
        for (int p = 0; p < 2; p++) begin
            base = (p == 0) ? 3 : 0;
            for (int k = 0; k < W; k++)
                exp_q.push_back(exp_t'{idx: AW'((base + k) % W), last: 1'(k == W - 1),
                                       data: (p == 0) ? row_vec((base + k) % W) : col_vec((base + k) % W)});
            @(negedge clock);
            start = 0;
            n_checks++;
            if (busy !== 1'b1 || read_op !== ((p == 0) ? OP_ROW : OP_COL))
                $display("FAIL b2b_start p=%0d got busy=%0b op=%0d, want busy=1 op=%0d", p, busy, read_op, (p == 0) ? OP_ROW : OP_COL);
            else n_pass++;
            seen = 0;
            for (int c = 2; c <= 30 && !seen; c++) begin
                @(negedge clock);
                if (c == 3) begin start = 1; start_count = 2; start_base = 5; end
                if (c == 4) start = 0;
                if (sif.out_valid && sif.out_ready) begin
                    obs = {sif.out_index, sif.out_last, sif.out_data};
                    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                    n_checks++;
                    if (obs !== e)
                        $display("FAIL b2b_vec p=%0d cyc=%0d got idx=%0d last=%0b data=%h, want idx=%0d last=%0b data=%h",
                                 p, c, obs.idx, obs.last, obs.data, e.idx, e.last, e.data);
                    else n_pass++;
                end
                if (done) begin
                    seen = 1;
                    n_checks++;
                    if (c !== 10 || exp_q.size() != 0)
                        $display("FAIL b2b_done p=%0d got cyc=%0d left=%0d, want cyc=10 left=0", p, c, exp_q.size());
                    else n_pass++;
                    if (p == 0) begin start = 1; start_col = 1; start_count = 9; start_base = 0; end
                end
            end
            if (!seen) begin n_checks++; $display("FAIL b2b_timeout p=%0d got no done, want done at cyc 10", p); end
            exp_q.delete();
        end
    endtask

    task automatic test_count_one();
        @(negedge clock);
        start = 1; start_col = 0; start_count = 1; start_base = 5; sif.out_ready = 0;
        @(negedge clock);
        start = 0;
        n_checks++;
        if (sif.out_valid !== 1'b0 || read_op !== OP_ROW || read_param1 !== 3'd5)
            $display("FAIL one_c1 got valid=%0b op=%0d p1=%0d, want 0 %0d 5", sif.out_valid, read_op, read_param1, OP_ROW);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if ({sif.out_valid, sif.out_last, sif.out_index, busy, read_op} !== {1'b1, 1'b1, 3'd5, 1'b1, OP_DIS} || sif.out_data !== row_vec(5))
            $display("FAIL one_c2 got valid=%0b last=%0b idx=%0d busy=%0b op=%0d data=%h, want 1 1 5 1 0 data=%h",
                     sif.out_valid, sif.out_last, sif.out_index, busy, read_op, sif.out_data, row_vec(5));
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (sif.out_valid !== 1'b1 || done !== 1'b0)
            $display("FAIL one_hold got valid=%0b done=%0b, want valid=1 done=0", sif.out_valid, done);
        else n_pass++;
        sif.out_ready = 1;
        @(negedge clock);
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || sif.out_valid !== 1'b0)
            $display("FAIL one_done got done=%0b busy=%0b valid=%0b, want 1 0 0", done, busy, sif.out_valid);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) $display("FAIL one_pulse got done=%0b, want 0", done);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        exp_t e, obs;
        bit seen = 0;
        for (int k = 0; k < 5; k++) exp_q.push_back(exp_t'{idx: AW'(1 + k), last: 1'(k == 4), data: row_vec(1 + k)});
        @(negedge clock);
        start = 1; start_col = 0; start_count = 5; start_base = 1; sif.out_ready = 1;
        @(negedge clock);
        start = 0;
        for (int c = 2; c <= 5; c++) begin
            @(negedge clock);
            sif.out_ready = (c <= 3);
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_index, sif.out_last, sif.out_data};
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                n_checks++;
                if (obs !== e)
                    $display("FAIL rst_vec cyc=%0d got idx=%0d data=%h, want idx=%0d data=%h", c, obs.idx, obs.data, e.idx, e.data);
                else n_pass++;
            end
        end
        n_checks++;
        if (sif.out_valid !== 1'b1 || sif.out_index !== 3'd3)
            $display("FAIL rst_stall got valid=%0b idx=%0d, want valid=1 idx=3", sif.out_valid, sif.out_index);
        else n_pass++;
        reset = 1;
        @(negedge clock);
        reset = 0;
        exp_q.delete();
        n_checks++;
        if ({sif.out_valid, sif.out_last, sif.out_index, busy, done, read_op, read_param1, read_param2} !== '0 || sif.out_data !== '0)
            $display("FAIL rst_values got valid=%0b last=%0b idx=%0d busy=%0b done=%0b op=%0d p1=%0d p2=%0d data=%h, want all 0",
                     sif.out_valid, sif.out_last, sif.out_index, busy, done, read_op, read_param1, read_param2, sif.out_data);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_nodone got done=%0b busy=%0b, want 0 0", done, busy);
        else n_pass++;
        for (int k = 0; k < 2; k++) exp_q.push_back(exp_t'{idx: AW'(4 + k), last: 1'(k == 1), data: col_vec(4 + k)});
        start = 1; start_col = 1; start_count = 2; start_base = 4; sif.out_ready = 1;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clock);
            start = 0;
            if (sif.out_valid && sif.out_ready) begin
                obs = {sif.out_index, sif.out_last, sif.out_data};
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                n_checks++;
                if (obs !== e)
                    $display("FAIL rst_after_vec cyc=%0d got idx=%0d last=%0b data=%h, want idx=%0d last=%0b data=%h",
                             c, obs.idx, obs.last, obs.data, e.idx, e.last, e.data);
                else n_pass++;
            end
            if (done) begin
                seen = 1;
                n_checks++;
                if (c !== 4 || exp_q.size() != 0)
                    $display("FAIL rst_after_done got cyc=%0d left=%0d, want cyc=4 left=0", c, exp_q.size());
                else n_pass++;
            end
        end
        if (!seen) begin n_checks++; $display("FAIL rst_after_timeout got no done, want done at cyc 4"); end
        exp_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        start_col = 1'b0;
        start_count = '0;
        start_base = '0;
        sif.out_ready = 1'b0;
        test_reset();
        test_rows();
        test_cols();
        test_backpressure();
        test_back_to_back();
        test_count_one();
        test_reset_mid();
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no end of run by 100000, want bench to finish");
        $fatal(1, "watchdog");
    end
endmodule
